sp_ram_arbiter: RTL

- Sits directly upstream of sp_ram and drives its single port.
- Arbitrates between an instruction-fetch master (read-only) and a data master (read/write) using a req/gnt/rvalid handshake.
- Routes the RAM's one-cycle-latency read data back to the master that issued the access.
- Flags out-of-range accesses with an error response and counts arbitration conflicts.

---
 rtl/sp_ram_arb_pkg.sv | 24 ++
 rtl/sp_ram_arbiter_if.sv | 58 +++++
 rtl/rr_arb2.sv | 36 +++
 rtl/sp_ram_arbiter.sv | 106 ++++++++++
 4 files changed

// File: rtl/sp_ram_arb_pkg.sv
// Shared types for the single-port RAM arbiter.
// Master identifiers and the registered response-tracker record.
package sp_ram_arb_pkg;

  typedef enum logic {
    MST_INSTR = 1'b0,
    MST_DATA  = 1'b1
  } master_e;

  typedef struct packed {
    logic    valid;
    master_e master;
    logic    err;
    logic    we;
  } rsp_t;

  localparam rsp_t RSP_IDLE = '{
    valid:  1'b0,
    master: MST_INSTR,
    err:    1'b0,
    we:     1'b0
  };

endpackage

// File: rtl/sp_ram_arbiter_if.sv
// Bus bundle for the arbiter: fetch port, data port and RAM port.
// slave faces the arbiter, master faces the surrounding masters/RAM.
interface sp_ram_arbiter_if #(
  parameter int RAM_ADDR_WIDTH = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int CNT_WIDTH      = 16
);
  logic                      instr_req_i;
  logic [31:0]               instr_addr_i;
  logic                      instr_gnt_o;
  logic                      instr_rvalid_o;
  logic [DATA_WIDTH-1:0]     instr_rdata_o;
  logic                      instr_err_o;

  logic                      data_req_i;
  logic [31:0]               data_addr_i;
  logic                      data_we_i;
  logic [DATA_WIDTH/8-1:0]   data_be_i;
  logic [DATA_WIDTH-1:0]     data_wdata_i;
  logic                      data_gnt_o;
  logic                      data_rvalid_o;
  logic [DATA_WIDTH-1:0]     data_rdata_o;
  logic                      data_err_o;

  logic                      ram_en_o;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr_o;
  logic                      ram_we_o;
  logic [DATA_WIDTH/8-1:0]   ram_be_o;
  logic [DATA_WIDTH-1:0]     ram_wdata_o;
  logic [DATA_WIDTH-1:0]     ram_rdata_i;

  logic [CNT_WIDTH-1:0]      conflict_cnt_o;

  modport slave (
    input  instr_req_i, instr_addr_i,
    input  data_req_i, data_addr_i, data_we_i,
    input  data_be_i, data_wdata_i, ram_rdata_i,
    output instr_gnt_o, instr_rvalid_o,
    output instr_rdata_o, instr_err_o,
    output data_gnt_o, data_rvalid_o,
    output data_rdata_o, data_err_o,
    output ram_en_o, ram_addr_o, ram_we_o,
    output ram_be_o, ram_wdata_o, conflict_cnt_o
  );

  modport master (
    output instr_req_i, instr_addr_i,
    output data_req_i, data_addr_i, data_we_i,
    output data_be_i, data_wdata_i, ram_rdata_i,
    input  instr_gnt_o, instr_rvalid_o,
    input  instr_rdata_o, instr_err_o,
    input  data_gnt_o, data_rvalid_o,
    input  data_rdata_o, data_err_o,
    input  ram_en_o, ram_addr_o, ram_we_o,
    input  ram_be_o, ram_wdata_o, conflict_cnt_o
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter; bit 0 = fetch, bit 1 = data.
// On a tie the master that did not win last time is granted.
module rr_arb2
  import sp_ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  master_e last_grant;

  always_comb begin
    gnt = '0;
    if (!rst) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_grant == MST_INSTR) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= MST_INSTR;
    end else if (gnt[1]) begin
      last_grant <= MST_DATA;
    end else if (gnt[0]) begin
      last_grant <= MST_INSTR;
    end
  end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Arbitrates fetch and data masters onto one RAM port and routes
// the one-cycle-latency read data back to the issuing master.
module sp_ram_arbiter
  import sp_ram_arb_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 8,
  parameter int RAM_BYTES      = 256,
  parameter int DATA_WIDTH     = 32,
  parameter int CNT_WIDTH      = 16
) (
  input logic             clk,
  input logic             rst,
  sp_ram_arbiter_if.slave bus
);

  logic [1:0]  req;
  logic [1:0]  gnt;
  logic        sel_data;
  logic        in_range;
  logic        hit;
  logic [31:0] addr;
  rsp_t        trk;
  logic        rsp_ok;

  assign req = {bus.data_req_i, bus.instr_req_i};

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );

  assign sel_data = gnt[1];
  assign addr     = sel_data ? bus.data_addr_i
                             : bus.instr_addr_i;
  assign in_range = addr < 32'(RAM_BYTES);
  assign hit      = (|gnt) & in_range;

  assign bus.instr_gnt_o = gnt[0];
  assign bus.data_gnt_o  = gnt[1];

  // Out-of-range grants still take a turn but leave the RAM idle
  always_comb begin
    bus.ram_en_o    = 1'b0;
    bus.ram_addr_o  = '0;
    bus.ram_we_o    = 1'b0;
    bus.ram_be_o    = '0;
    bus.ram_wdata_o = '0;
    if (hit) begin
      bus.ram_en_o   = 1'b1;
      bus.ram_addr_o = addr[RAM_ADDR_WIDTH-1:0];
      if (sel_data) begin
        bus.ram_we_o    = bus.data_we_i;
        bus.ram_be_o    = bus.data_be_i;
        bus.ram_wdata_o = bus.data_wdata_i;
      end else begin
        bus.ram_be_o = '1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trk <= RSP_IDLE;
    end else begin
      trk.valid  <= |gnt;
      trk.master <= sel_data ? MST_DATA : MST_INSTR;
      trk.err    <= ~in_range;
      trk.we     <= sel_data & bus.data_we_i;
    end
  end

  assign rsp_ok = trk.valid & ~trk.err & ~trk.we;

  always_comb begin
    bus.instr_rvalid_o = 1'b0;
    bus.instr_rdata_o  = '0;
    bus.instr_err_o    = 1'b0;
    bus.data_rvalid_o  = 1'b0;
    bus.data_rdata_o   = '0;
    bus.data_err_o     = 1'b0;
    unique case (1'b1)
      !trk.valid: ;
      trk.master == MST_DATA: begin
        bus.data_rvalid_o = 1'b1;
        bus.data_err_o    = trk.err;
        if (rsp_ok) bus.data_rdata_o = bus.ram_rdata_i;
      end
      default: begin
        bus.instr_rvalid_o = 1'b1;
        bus.instr_err_o    = trk.err;
        if (rsp_ok) bus.instr_rdata_o = bus.ram_rdata_i;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.conflict_cnt_o <= '0;
    end else if (&req && !(&bus.conflict_cnt_o)) begin
      bus.conflict_cnt_o <= bus.conflict_cnt_o + 1'b1;
    end
  end

endmodule
